two_power_mod_arbiter: RTL and testbench

- Shares one two_power_mod engine (2^power mod modulus, non-pipelined, one job in flight) among NUM_REQ requesters.
- Round-robin grant; captures the winner's operands, issues them to the engine, collects the result and returns it to the granted requester only.
- Handles power==0 locally, without using the engine.
- Sits between the RSA precompute clients (e.g. Montgomery R/R^2 constant generation) and the shared engine instance.

---
 rtl/two_power_mod_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/two_power_mod_arbiter.sv | 121 ++++++++++++
 tb/tb_two_power_mod_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/two_power_mod_pkg.sv
// Shared types and helpers for the two_power_mod arbiter family.
package two_power_mod_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_e;

  // 2^0 mod m is 1, except that 1 mod 1 collapses to 0; only the LSB can be set.
  function automatic logic bypass_bit(input logic modulus_is_one);
    return ~modulus_is_one;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req scanning ptr+1, ptr+2, ... modulo N.
module rr_pick #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id
);

  logic [IW-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/two_power_mod_arbiter.sv
// Round-robin front end sharing one 2^power mod modulus engine among NUM_REQ requesters.
module two_power_mod_arbiter
  import two_power_mod_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  MOD_WIDTH   = 256,
  parameter int  POWER_WIDTH = 32,
  localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             i_valid,
  output logic [NUM_REQ-1:0]             i_ready,
  input  logic [NUM_REQ*MOD_WIDTH-1:0]   i_modulus,
  input  logic [NUM_REQ*POWER_WIDTH-1:0] i_power,
  output logic [NUM_REQ-1:0]             o_valid,
  input  logic [NUM_REQ-1:0]             o_ready,
  output logic [MOD_WIDTH-1:0]           o_out,
  output logic [ID_WIDTH-1:0]            o_id,
  output logic                           e_valid,
  input  logic                           e_ready,
  output logic [MOD_WIDTH-1:0]           e_modulus,
  output logic [POWER_WIDTH-1:0]         e_power,
  input  logic                           r_valid,
  output logic                           r_ready,
  input  logic [MOD_WIDTH-1:0]           r_out
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_e                   state_q, state_d;
  logic [ID_WIDTH-1:0]      ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic [MOD_WIDTH-1:0]     mod_q, mod_d;
  logic [POWER_WIDTH-1:0]   pow_q, pow_d;
  logic [MOD_WIDTH-1:0]     res_q, res_d;

  logic                     grant_valid;
  logic [ID_WIDTH-1:0]      grant_id;
  logic [MOD_WIDTH-1:0]     sel_mod;
  logic [POWER_WIDTH-1:0]   sel_pow;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req         (i_valid),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_mod = i_modulus[grant_id*MOD_WIDTH +: MOD_WIDTH];
  assign sel_pow = i_power[grant_id*POWER_WIDTH +: POWER_WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    mod_d   = mod_q;
    pow_d   = pow_q;
    res_d   = res_q;
    i_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          i_ready = ONE << grant_id;
          id_d    = grant_id;
          mod_d   = sel_mod;
          pow_d   = sel_pow;
          if (sel_pow == '0) begin
            res_d   = MOD_WIDTH'(bypass_bit(sel_mod == MOD_WIDTH'(1)));
            state_d = RETURN;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: if (e_ready) state_d = WAIT;
      WAIT: begin
        if (r_valid) begin
          res_d   = r_out;
          state_d = RETURN;
        end
      end
      RETURN: begin
        // Only the answered requester's ready bit can retire the response.
        if (o_ready[id_q]) begin
          ptr_d   = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
      id_q    <= '0;
      mod_q   <= '0;
      pow_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      mod_q   <= mod_d;
      pow_q   <= pow_d;
      res_q   <= res_d;
    end
  end

  assign e_valid   = (state_q == ISSUE);
  assign r_ready   = (state_q == WAIT);
  assign o_valid   = (state_q == RETURN) ? (ONE << id_q) : '0;
  assign o_out     = res_q;
  assign o_id      = id_q;
  assign e_modulus = mod_q;
  assign e_power   = pow_q;

endmodule

// File: tb/tb_two_power_mod_arbiter.sv
// Randomized bench for two_power_mod_arbiter; the bench itself plays the engine and the requesters.
module tb_two_power_mod_arbiter;

  localparam int N  = 4;
  localparam int MW = 256;
  localparam int PW = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      i_valid, i_ready, o_valid, o_ready;
  logic [N*MW-1:0]   i_modulus;
  logic [N*PW-1:0]   i_power;
  logic [MW-1:0]     o_out, e_modulus, r_out;
  logic [IW-1:0]     o_id;
  logic              e_valid, e_ready, r_valid, r_ready;
  logic [PW-1:0]     e_power;

  int vectors     = 0;
  int miscompares = 0;

  logic [MW-1:0] req_mod [N];
  logic [PW-1:0] req_pow [N];
  logic [N-1:0]  pending;
  int            ptr_m;

  always #5 clk = ~clk;

  two_power_mod_arbiter #(.NUM_REQ(N), .MOD_WIDTH(MW), .POWER_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_modulus(i_modulus), .i_power(i_power),
    .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out), .o_id(o_id),
    .e_valid(e_valid), .e_ready(e_ready), .e_modulus(e_modulus), .e_power(e_power),
    .r_valid(r_valid), .r_ready(r_ready), .r_out(r_out)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      i_modulus[k*MW +: MW] = req_mod[k];
      i_power[k*PW +: PW]   = req_pow[k];
    end
    i_valid = pending;
  endtask

  // Reference: 2^p mod m by repeated doubling.
  function automatic logic [MW-1:0] ref_result(input logic [MW-1:0] m, input logic [PW-1:0] p);
    logic [MW:0] r;
    r = (m == MW'(1)) ? '0 : (MW+1)'(1);
    for (longint i = 0; i < longint'(p); i++) r = (r << 1) % {1'b0, m};
    return r[MW-1:0];
  endfunction

  // Reference: first pending requester after ptr, wrapping.
  function automatic int ref_pick(input logic [N-1:0] pend, input int ptr);
    for (int i = 1; i <= N; i++) begin
      if (pend[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0; i_valid = '0; o_ready = '0; e_ready = 1'b0; r_valid = 1'b0; r_out = '0;
    i_modulus = '0; i_power = '0;
    pending = '0; ptr_m = N - 1;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  // One full job for the model's next winner, with optional backpressure on both sides.
  task automatic one_job(input int bp, input int rdly, input int lat);
    int w;
    logic [N-1:0] oh;
    logic [MW-1:0] exp_res;
    drive_reqs();
    #1;
    w  = ref_pick(pending, ptr_m);
    oh = (w < 0) ? '0 : (N'(1) << w);
    vectors++;
    if (i_ready !== oh) begin
      miscompares++; $display("FAIL grant: i_ready=%b expected %b", i_ready, oh);
    end
    if (w < 0) return;
    exp_res = ref_result(req_mod[w], req_pow[w]);
    step();
    pending[w] = 1'b0;
    i_valid    = pending;
    #1;
    vectors++;
    if (i_ready !== '0) begin
      miscompares++; $display("FAIL busy_ready: i_ready=%b expected 0", i_ready);
    end
    if (req_pow[w] == '0) begin
      vectors++;
      if (o_valid !== oh || e_valid !== 1'b0) begin
        miscompares++; $display("FAIL bypass: o_valid=%b e_valid=%b expected %b/0", o_valid, e_valid, oh);
      end
    end else begin
      vectors++;
      if (e_valid !== 1'b1 || e_modulus !== req_mod[w] || e_power !== req_pow[w]) begin
        miscompares++;
        $display("FAIL issue: e_valid=%b e_mod=%0h e_pow=%0d expected 1/%0h/%0d",
                 e_valid, e_modulus, e_power, req_mod[w], req_pow[w]);
      end
      repeat (rdly) begin
        e_ready = 1'b0; r_valid = 1'b1; r_out = {8{$urandom}};
        step();
        vectors++;
        if (e_valid !== 1'b1 || r_ready !== 1'b0 || e_modulus !== req_mod[w] || e_power !== req_pow[w]) begin
          miscompares++;
          $display("FAIL issue_hold: e_valid=%b r_ready=%b e_mod=%0h e_pow=%0d expected 1/0/%0h/%0d",
                   e_valid, r_ready, e_modulus, e_power, req_mod[w], req_pow[w]);
        end
      end
      r_valid = 1'b0; e_ready = 1'b1;
      step();
      e_ready = 1'b0;
      vectors++;
      if (e_valid !== 1'b0 || r_ready !== 1'b1) begin
        miscompares++; $display("FAIL wait: e_valid=%b r_ready=%b expected 0/1", e_valid, r_ready);
      end
      repeat (lat) step();
      r_valid = 1'b1; r_out = exp_res;
      step();
      r_valid = 1'b0; r_out = {8{$urandom}};
    end
    o_ready = ~oh;
    repeat (bp) begin
      vectors++;
      if (o_valid !== oh || o_out !== exp_res || o_id !== IW'(w) || i_ready !== '0 || e_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL resp_hold: o_valid=%b o_out=%0h o_id=%0d i_ready=%b e_valid=%b expected %b/%0h/%0d/0/0",
                 o_valid, o_out, o_id, i_ready, e_valid, oh, exp_res, w);
      end
      step();
    end
    vectors++;
    if (o_valid !== oh || o_out !== exp_res || o_id !== IW'(w)) begin
      miscompares++;
      $display("FAIL response: o_valid=%b o_out=%0h o_id=%0d expected %b/%0h/%0d",
               o_valid, o_out, o_id, oh, exp_res, w);
    end
    o_ready = oh;
    step();
    o_ready = '0;
    ptr_m   = w;
    vectors++;
    if (o_valid !== '0) begin
      miscompares++; $display("FAIL retire: o_valid=%b expected 0", o_valid);
    end
  endtask

  task automatic run_all(input int bp, input int rdly, input int lat);
    for (int j = 0; j < N && pending != '0; j++) one_job(bp, rdly, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0; i_valid = '0; o_ready = '0; e_ready = 1'b0; r_valid = 1'b0; r_out = '0;
    i_modulus = '0; i_power = '0; pending = '0; ptr_m = N - 1;
    #3;
    vectors++;
    if ({i_ready, o_valid, e_valid, r_ready} !== '0 || o_out !== '0 || o_id !== '0 ||
        e_modulus !== '0 || e_power !== '0) begin
      miscompares++; $display("FAIL reset_outputs: some output nonzero during reset");
    end
    step(); step();
    rst = 1'b1;
    step();
    #1;
    vectors++;
    if (i_ready !== '0) begin
      miscompares++; $display("FAIL idle_no_req: i_ready=%b expected 0", i_ready);
    end
  endtask

  task automatic test_single();
    req_mod[0] = MW'(13); req_pow[0] = PW'(4);
    pending = 4'b0001;
    run_all(0, 0, 2);
  endtask

  task automatic test_all_four();
    do_reset();
    for (int k = 0; k < N; k++) req_mod[k] = MW'(7);
    req_pow[0] = 1; req_pow[1] = 2; req_pow[2] = 3; req_pow[3] = 5;
    pending = 4'b1111;
    run_all(0, 0, 1);
    pending = 4'b1010;
    run_all(0, 1, 0);
  endtask

  task automatic test_bypass();
    req_mod[2] = MW'(7); req_pow[2] = '0; pending = 4'b0100;
    run_all(0, 0, 0);
    req_mod[2] = MW'(1); pending = 4'b0100;
    run_all(1, 0, 0);
  endtask

  task automatic test_backpressure();
    req_mod[0] = MW'(13); req_pow[0] = PW'(7); pending = 4'b0001;
    run_all(10, 0, 1);
  endtask

  task automatic test_engine_bp();
    r_valid = 1'b1; r_out = MW'(99);
    repeat (2) begin
      step();
      vectors++;
      if (r_ready !== 1'b0 || o_valid !== '0 || e_valid !== 1'b0) begin
        miscompares++; $display("FAIL idle_spurious: r_ready=%b o_valid=%b e_valid=%b expected 0", r_ready, o_valid, e_valid);
      end
    end
    r_valid = 1'b0;
    req_mod[3] = MW'(1000003); req_pow[3] = PW'(100); pending = 4'b1000;
    run_all(0, 5, 3);
  endtask

  task automatic test_reset_mid();
    req_mod[3] = MW'(7); req_pow[3] = PW'(5); pending = 4'b1000;
    drive_reqs();
    step();
    i_valid = '0; e_ready = 1'b1;
    step();
    e_ready = 1'b0;
    step();
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({i_ready, o_valid, e_valid, r_ready} !== '0 || o_out !== '0 || o_id !== '0 ||
        e_modulus !== '0 || e_power !== '0) begin
      miscompares++; $display("FAIL reset_mid: outputs not cleared, e_mod=%0h e_pow=%0d", e_modulus, e_power);
    end
    pending = '0; ptr_m = N - 1;
    step(); step();
    rst = 1'b1;
    req_mod[1] = MW'(11); req_pow[1] = PW'(10);
    req_mod[0] = MW'(5);  req_pow[0] = PW'(3);
    pending = 4'b0011;
    run_all(0, 0, 1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) req_mod[k] = MW'(1);
        else if (sel < 4) req_mod[k] = {8{$urandom}} | MW'(2);
        else req_mod[k] = MW'($urandom | 32'd2);
        req_pow[k] = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom_range(1, 300));
      end
      pending = N'($urandom_range(1, (1 << N) - 1));
      run_all($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_bypass();
    test_backpressure();
    test_engine_bp();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
